// File: rtl/esp32_prog_sequencer.sv
// ESP32 auto-program sequencer: turns the FTDI DTR#/RTS# handshake into EN/GPIO0 strap
// timing with an enforced minimum reset pulse and a timed strap window.
module esp32_prog_sequencer #(
  parameter int C_release_bits = 17,
  parameter int C_min_reset    = 250,
  parameter int C_sync_stages  = 2
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       ftdi_ndtr,
  input  logic       ftdi_nrts,
  input  logic       btn_hold_n,
  output logic       wifi_en,
  output logic       wifi_gpio0,
  output logic       prog_window,
  output logic       strap_done,
  output logic [1:0] state,
  output logic [7:0] prog_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RST   = 2'b01,
    ST_STRAP = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  localparam int              WC_W    = C_release_bits + 1;
  localparam logic [15:0]     RC_LOAD = 16'(C_min_reset - 1);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);

  // Maps synchronized {DTR#, RTS#} to the requested {EN, GPIO0} levels.
  function automatic logic [1:0] decode_lines(input logic [1:0] s);
    logic [1:0] d;
    case (s)
      2'b10:   d = 2'b01;
      2'b01:   d = 2'b10;
      default: d = 2'b11;
    endcase
    return d;
  endfunction

  logic [C_sync_stages-1:0] dtr_sync_r;
  logic [C_sync_stages-1:0] rts_sync_r;
  logic [C_sync_stages-1:0] btn_sync_r;

  logic [1:0]      s_s;
  logic [1:0]      d_s;
  logic            b_s;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [15:0]     rc_r;
  logic [15:0]     rc_nxt_s;
  logic [WC_W-1:0] wc_r;
  logic [WC_W-1:0] wc_nxt_s;
  logic [WC_W-1:0] wc_inc_s;
  logic [7:0]      count_r;
  logic [7:0]      count_nxt_s;
  logic            en_r;
  logic            en_nxt_s;
  logic            gpio0_r;
  logic            gpio0_nxt_s;
  logic            window_r;
  logic            done_r;
  logic            done_nxt_s;

  // Input synchronizers; idle level is high so reset leaves every line inactive.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      dtr_sync_r <= {C_sync_stages{1'b1}};
      rts_sync_r <= {C_sync_stages{1'b1}};
      btn_sync_r <= {C_sync_stages{1'b1}};
    end else begin
      dtr_sync_r <= {dtr_sync_r[C_sync_stages-2:0], ftdi_ndtr};
      rts_sync_r <= {rts_sync_r[C_sync_stages-2:0], ftdi_nrts};
      btn_sync_r <= {btn_sync_r[C_sync_stages-2:0], btn_hold_n};
    end
  end

  assign s_s      = {dtr_sync_r[C_sync_stages-1], rts_sync_r[C_sync_stages-1]};
  assign d_s      = decode_lines(s_s);
  assign b_s      = btn_sync_r[C_sync_stages-1];
  assign wc_inc_s = wc_r + WC_ONE;

  // Next-state, counter and next-output decode; outputs follow the state being entered.
  always_comb begin
    state_nxt_s = state_r;
    rc_nxt_s    = rc_r;
    wc_nxt_s    = wc_r;
    count_nxt_s = count_r;
    en_nxt_s    = d_s[1];
    gpio0_nxt_s = d_s[0] & b_s;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (d_s == 2'b01) begin
          state_nxt_s = ST_RST;
          rc_nxt_s    = RC_LOAD;
          en_nxt_s    = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RST: begin
        if (rc_r != 16'd0) begin
          rc_nxt_s = rc_r - 16'd1;
          en_nxt_s = 1'b0;
        end else if (d_s == 2'b01) begin
          en_nxt_s = 1'b0;
        end else if ((d_s == 2'b10) || !b_s) begin
          state_nxt_s = ST_STRAP;
          wc_nxt_s    = '0;
          count_nxt_s = (count_r == 8'hFF) ? 8'hFF : count_r + 8'd1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STRAP: begin
        // A new reset request aborts the window before the timeout is considered.
        if (d_s == 2'b01) begin
          state_nxt_s = ST_RST;
          rc_nxt_s    = RC_LOAD;
          en_nxt_s    = 1'b0;
        end else if (wc_inc_s[C_release_bits]) begin
          state_nxt_s = ST_IDLE;
          wc_nxt_s    = wc_inc_s;
          done_nxt_s  = 1'b1;
        end else begin
          wc_nxt_s = wc_inc_s;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        en_nxt_s    = 1'b1;
        gpio0_nxt_s = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      rc_r     <= 16'd0;
      wc_r     <= '0;
      count_r  <= 8'd0;
      en_r     <= 1'b1;
      gpio0_r  <= 1'b1;
      window_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      rc_r     <= rc_nxt_s;
      wc_r     <= wc_nxt_s;
      count_r  <= count_nxt_s;
      en_r     <= en_nxt_s;
      gpio0_r  <= gpio0_nxt_s;
      window_r <= (state_nxt_s == ST_STRAP);
      done_r   <= done_nxt_s;
    end
  end

  assign wifi_en     = en_r;
  assign wifi_gpio0  = gpio0_r;
  assign prog_window = window_r;
  assign strap_done  = done_r;
  assign state       = state_r;
  assign prog_count  = count_r;

endmodule
